or1200_qmem_arb: RTL and testbench
==================================

// Module: or1200_qmem_arb
// PURPOSE
// - Shares the single-port QMEM SRAM between instruction fetch (IF) and the data unit (DU: load/store).
// - Decodes QMEM address hits, grants one access per cycle with DU priority, drives the SRAM, returns acks/data.
// - state_o exposes the IDLE/STORE/LOAD/FETCH FSM for assertion binding. Sits inside or1200_qmem_top.
// PARAMETERS
// - QMEM_BASE  32'h0080_0000  base address of the QMEM window
// - QMEM_MASK  32'hFFFF_C000  compare mask; hit = (adr & QMEM_MASK) == QMEM_BASE
// - RAM_AW     12             SRAM word-address width (2^RAM_AW x 32 bit)
// PORTS
// - clk             in   1       clock, rising edge
// - rst             in   1       synchronous reset, active-low
// - if_req_i        in   1       IF request, held until if_ack_o
// - if_adr_i        in   32      IF byte address
// - if_hit_o        out  1       if_adr_i inside QMEM window (combinational)
// - if_ack_o        out  1       IF access complete, if_dat_o valid
// - if_dat_o        out  32      fetched word
// - du_req_i        in   1       DU request, held until du_ack_o
// - du_we_i         in   1       1 = store, 0 = load
// - du_sel_i        in   4       store byte enables
// - du_adr_i        in   32      DU byte address
// - du_dat_i        in   32      store data
// - du_hit_o        out  1       du_adr_i inside QMEM window (combinational)
// - du_ack_o        out  1       DU access complete (load data valid on du_dat_o)
// - du_dat_o        out  32      load data
// - ram_en_o        out  1       SRAM enable
// - ram_we_o        out  4       SRAM byte write enables
// - ram_addr_o      out  RAM_AW  SRAM word address = adr[RAM_AW+1:2]
// - ram_di_o        out  32      SRAM write data
// - ram_do_i        in   32      SRAM read data, valid cycle after ram_en_o
// - state_o         out  3       FSM state
// - if_stall_cnt_o  out  16      cycles IF waited due to DU conflict, saturating
// BEHAVIOUR
// - Reset (rst=0 at edge): state IDLE, acks 0, if_stall_cnt_o 0; ram_en_o/ram_we_o 0 combinationally while state IDLE and no eligible request.
// - Eligible: du_el = du_req_i & du_hit_o & ~du_ack_o; if_el = if_req_i & if_hit_o & ~if_ack_o (acked requester masked in its ack cycle).
// - Arbitration, cycle N, combinational: du_el wins; else if_el; else no access.
//   ram_en_o=1, ram_addr_o from winner, ram_we_o = du_we_i ? du_sel_i : 0, ram_di_o = du_dat_i.
// - Next state (registered at N+1): du_el&du_we_i -> STORE; du_el&~du_we_i -> LOAD; ~du_el&if_el -> FETCH; else IDLE.
//   Transitions identical from every state; no multi-cycle states.
// - Acks (no DOREG): du_ack_o = state in {STORE,LOAD}; if_ack_o = state==FETCH; latency 1 cycle from grant.
//   du_dat_o = if_dat_o = ram_do_i (valid only with respective ack).
// - Back-to-back: alternating DU/IF gives one SRAM access every cycle; same requester max 1 per 2 cycles.
// - Conflict: du_el & if_el -> IF waits; if_stall_cnt_o += 1 per such cycle, holds at 16'hFFFF.
// - Non-hit requests never touch SRAM or the FSM; acks stay 0 (top routes them elsewhere).
// - Reset mid-access: in-flight op dropped, no ack issued; requester reissues. SRAM write already done stays done.
// CONFIGURATION
// - OR1200_QMEM_DOREG_EN defined: ram_do_i registered; state pipelined one extra stage; acks and
//   data at N+2; ack-cycle masking applies to both stages (no re-grant while own access in flight).
// - Undefined: 1-cycle latency as above, no output data register.
// STRUCTURE
// - or1200_qmem_pkg: qmem_state_t enum {IDLE=3'd0, STORE=3'd1, LOAD=3'd2, FETCH=3'd3}, RAM word width, stall-counter width.
// - Sub-module or1200_qmem_addr_dec (adr, base, mask -> hit), instantiated twice (IF, DU).
// TESTING
// - Reset: rst=0 2 cycles with requests active -> state_o=0, acks 0, ram_en_o 0, if_stall_cnt_o 0.
// - Load: du_req, we=0, adr 32'h0080_0010, RAM word 4 = 32'hDEAD_BEEF -> ram_addr_o=4, next cycle state LOAD, du_ack, du_dat_o=DEADBEEF.
// - Store: we=1, sel=4'b0011, dat 32'h1234_5678 at 32'h0080_0020 -> ram_we_o=4'b0011 addr 8; next cycle STORE, du_ack.
// - Conflict: IF and DU load both hit at N -> LOAD at N+1, FETCH at N+2, if_stall_cnt_o=1.
// - Miss: du_adr 32'h0000_1000 -> du_hit_o=0, no ram_en_o, state stays IDLE, no ack.
// - Mid-op reset: grant LOAD at N, rst=0 at N+1 edge -> state IDLE, du_ack_o never asserted.

Source files
------------

// File: rtl/or1200_qmem_pkg.sv
// Shared types and widths for the QMEM arbiter: FSM state encoding, SRAM data width
// and IF stall-counter width.
package or1200_qmem_pkg;

  localparam int RAM_DW   = 32;
  localparam int STALL_CW = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STORE = 3'd1,
    LOAD  = 3'd2,
    FETCH = 3'd3
  } qmem_state_t;

  function automatic logic is_du_state(qmem_state_t s);
    return (s == STORE) || (s == LOAD);
  endfunction

endpackage

// File: rtl/or1200_qmem_arb_if.sv
// Bus bundle between the QMEM arbiter (slave modport) and its environment:
// IF port, DU port, SRAM port and observability outputs (master modport).
interface or1200_qmem_arb_if
  import or1200_qmem_pkg::*;
#(
  parameter int RAM_AW = 12
);
  logic                if_req_i;
  logic [31:0]         if_adr_i;
  logic                if_hit_o;
  logic                if_ack_o;
  logic [RAM_DW-1:0]   if_dat_o;

  logic                du_req_i;
  logic                du_we_i;
  logic [3:0]          du_sel_i;
  logic [31:0]         du_adr_i;
  logic [RAM_DW-1:0]   du_dat_i;
  logic                du_hit_o;
  logic                du_ack_o;
  logic [RAM_DW-1:0]   du_dat_o;

  logic                ram_en_o;
  logic [3:0]          ram_we_o;
  logic [RAM_AW-1:0]   ram_addr_o;
  logic [RAM_DW-1:0]   ram_di_o;
  logic [RAM_DW-1:0]   ram_do_i;

  logic [2:0]          state_o;
  logic [STALL_CW-1:0] if_stall_cnt_o;

  modport slave (
    input  if_req_i, if_adr_i, du_req_i, du_we_i, du_sel_i, du_adr_i, du_dat_i, ram_do_i,
    output if_hit_o, if_ack_o, if_dat_o, du_hit_o, du_ack_o, du_dat_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_di_o, state_o, if_stall_cnt_o
  );

  modport master (
    output if_req_i, if_adr_i, du_req_i, du_we_i, du_sel_i, du_adr_i, du_dat_i, ram_do_i,
    input  if_hit_o, if_ack_o, if_dat_o, du_hit_o, du_ack_o, du_dat_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_di_o, state_o, if_stall_cnt_o
  );
endinterface

// File: rtl/or1200_qmem_addr_dec.sv
// QMEM window decoder: flags an address whose masked bits equal the window base.
module or1200_qmem_addr_dec (
  input  logic [31:0] i_adr,
  input  logic [31:0] i_base,
  input  logic [31:0] i_mask,
  output logic        o_hit
);
  assign o_hit = ((i_adr & i_mask) == i_base);
endmodule

// File: rtl/or1200_qmem_arb.sv
// Single-port QMEM SRAM arbiter between instruction fetch and the data unit (DU wins).
// Optional OR1200_QMEM_DOREG_EN registers read data and delays acks by one extra cycle.
module or1200_qmem_arb
  import or1200_qmem_pkg::*;
#(
  parameter logic [31:0] QMEM_BASE = 32'h0080_0000,
  parameter logic [31:0] QMEM_MASK = 32'hFFFF_C000,
  parameter int          RAM_AW    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  or1200_qmem_arb_if.slave          bus
);

  logic                w_if_hit, w_du_hit;
  logic                w_if_el, w_du_el;
  logic                w_du_busy, w_if_busy;
  logic                w_ram_en;
  logic [3:0]          w_ram_we;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic [RAM_DW-1:0]   w_rdata;
  qmem_state_t         r_state, w_state_nxt, w_ack_state;
  logic [STALL_CW-1:0] r_stall_cnt;

  or1200_qmem_addr_dec u_if_dec (
    .i_adr (bus.if_adr_i),
    .i_base(QMEM_BASE),
    .i_mask(QMEM_MASK),
    .o_hit (w_if_hit)
  );

  or1200_qmem_addr_dec u_du_dec (
    .i_adr (bus.du_adr_i),
    .i_base(QMEM_BASE),
    .i_mask(QMEM_MASK),
    .o_hit (w_du_hit)
  );

  // A requester whose access is still in flight (or being acked) cannot be re-granted;
  // nothing is granted while reset is held so the SRAM is left untouched.
  assign w_du_el = rst & bus.du_req_i & w_du_hit & ~w_du_busy;
  assign w_if_el = rst & bus.if_req_i & w_if_hit & ~w_if_busy;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = IDLE;
    w_ram_en    = 1'b0;
    w_ram_we    = 4'b0000;
    w_ram_addr  = bus.du_adr_i[RAM_AW+1:2];
    if (w_du_el) begin
      w_ram_en    = 1'b1;
      w_ram_we    = bus.du_we_i ? bus.du_sel_i : 4'b0000;
      w_state_nxt = bus.du_we_i ? STORE : LOAD;
    end else if (w_if_el) begin
      w_ram_en    = 1'b1;
      w_ram_addr  = bus.if_adr_i[RAM_AW+1:2];
      w_state_nxt = FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, active-low.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst)                                            r_stall_cnt <= '0;
    else if (w_du_el && w_if_el && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 1'b1;
  end

`ifdef OR1200_QMEM_DOREG_EN
  qmem_state_t       r_state_d;
  logic [RAM_DW-1:0] r_do;

  always_ff @(posedge clk) begin
    if (!rst) r_state_d <= IDLE;
    else      r_state_d <= r_state;
  end

  // NOTE: the read-data register is not reset; its value is only meaningful alongside an ack.
  always_ff @(posedge clk) r_do <= bus.ram_do_i;

  assign w_ack_state = r_state_d;
  assign w_du_busy   = is_du_state(r_state) | is_du_state(r_state_d);
  assign w_if_busy   = (r_state == FETCH) | (r_state_d == FETCH);
  assign w_rdata     = r_do;
`else
  assign w_ack_state = r_state;
  assign w_du_busy   = is_du_state(r_state);
  assign w_if_busy   = (r_state == FETCH);
  assign w_rdata     = bus.ram_do_i;
`endif

  assign bus.if_hit_o       = w_if_hit;
  assign bus.du_hit_o       = w_du_hit;
  assign bus.du_ack_o       = is_du_state(w_ack_state);
  assign bus.if_ack_o       = (w_ack_state == FETCH);
  assign bus.du_dat_o       = w_rdata;
  assign bus.if_dat_o       = w_rdata;
  assign bus.ram_en_o       = w_ram_en;
  assign bus.ram_we_o       = w_ram_we;
  assign bus.ram_addr_o     = w_ram_addr;
  assign bus.ram_di_o       = bus.du_dat_i;
  assign bus.state_o        = w_ack_state;
  assign bus.if_stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_or1200_qmem_arb.sv
// Self-checking bench for or1200_qmem_arb: SRAM model, transaction-level reference model,
// vector table, hand-written corner sequences and randomized traffic.
module tb_or1200_qmem_arb;

  localparam logic [31:0] BASE = 32'h0080_0000;
  localparam logic [31:0] MASK = 32'hFFFF_C000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  or1200_qmem_arb_if #(.RAM_AW(12)) bus ();

  or1200_qmem_arb #(.QMEM_BASE(BASE), .QMEM_MASK(MASK), .RAM_AW(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // SRAM: synchronous read, byte-write, data valid the cycle after enable
  logic [31:0] sram [4096] = '{default: 32'h0};
  logic [31:0] sram_nw;
  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      sram_nw = sram[bus.ram_addr_o];
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o[b]) sram_nw[8*b +: 8] = bus.ram_di_o[8*b +: 8];
      sram[bus.ram_addr_o] <= sram_nw;
      bus.ram_do_i         <= sram[bus.ram_addr_o];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which requester was served last cycle and what it should see
  logic [31:0] ref_mem [4096] = '{default: 32'h0};
  int          m_last = 0;      // 0 none, 1 DU, 2 IF: access served in previous cycle
  logic        m_last_we = 1'b0;
  int          m_grant = 0;
  logic        m_both = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_du_rd = '0, m_if_rd = '0;
  logic        s_du_ack, s_if_ack, s_du_hit, s_if_hit;

  task automatic model_check();
    logic du_hit, if_hit, du_el, if_el;
    int   exp_state;
    @(negedge clk);
    du_hit   = ((bus.du_adr_i & MASK) == BASE);
    if_hit   = ((bus.if_adr_i & MASK) == BASE);
    s_du_ack = (m_last == 1);
    s_if_ack = (m_last == 2);
    s_du_hit = du_hit;
    s_if_hit = if_hit;
    du_el    = rst && bus.du_req_i && du_hit && !s_du_ack;
    if_el    = rst && bus.if_req_i && if_hit && !s_if_ack;
    m_grant  = du_el ? 1 : (if_el ? 2 : 0);
    m_both   = du_el && if_el;
    exp_state = (m_last == 1) ? (m_last_we ? 1 : 2) : ((m_last == 2) ? 3 : 0);
    check("du_hit", 32'(bus.du_hit_o), 32'(du_hit));
    check("if_hit", 32'(bus.if_hit_o), 32'(if_hit));
    check("du_ack", 32'(bus.du_ack_o), 32'(s_du_ack));
    check("if_ack", 32'(bus.if_ack_o), 32'(s_if_ack));
    check("state", 32'(bus.state_o), 32'(exp_state));
    check("stall_cnt", 32'(bus.if_stall_cnt_o), 32'(m_cnt));
    check("ram_en", 32'(bus.ram_en_o), 32'(m_grant != 0));
    check("ram_we", 32'(bus.ram_we_o), (m_grant == 1 && bus.du_we_i) ? 32'(bus.du_sel_i) : 32'h0);
    if (m_grant != 0)
      check("ram_addr", 32'(bus.ram_addr_o),
            (m_grant == 1) ? 32'(bus.du_adr_i[13:2]) : 32'(bus.if_adr_i[13:2]));
    if (m_grant == 1 && bus.du_we_i) check("ram_di", bus.ram_di_o, bus.du_dat_i);
    if (s_du_ack && !m_last_we) check("du_dat", bus.du_dat_o, m_du_rd);
    if (s_if_ack) check("if_dat", bus.if_dat_o, m_if_rd);
  endtask

  task automatic advance();
    int w;
    @(posedge clk);
    if (!rst) begin
      m_last = 0;
      m_cnt  = 0;
    end else begin
      if (m_both && m_cnt < 65535) m_cnt++;
      if (m_grant == 1) begin
        w = int'(bus.du_adr_i[13:2]);
        m_last_we = bus.du_we_i;
        if (bus.du_we_i) begin
          for (int b = 0; b < 4; b++)
            if (bus.du_sel_i[b]) ref_mem[w][8*b +: 8] = bus.du_dat_i[8*b +: 8];
        end else m_du_rd = ref_mem[w];
      end else if (m_grant == 2) begin
        m_if_rd = ref_mem[int'(bus.if_adr_i[13:2])];
      end
      m_last = m_grant;
    end
    #1;
  endtask

  task automatic idle();
    bus.du_req_i = 1'b0;
    bus.if_req_i = 1'b0;
  endtask

  task automatic du_drive(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat);
    bus.du_req_i = 1'b1;
    bus.du_we_i  = we;
    bus.du_sel_i = sel;
    bus.du_adr_i = adr;
    bus.du_dat_i = dat;
  endtask

  task automatic if_drive(input logic [31:0] adr);
    bus.if_req_i = 1'b1;
    bus.if_adr_i = adr;
  endtask

  function automatic logic [31:0] rand_adr();
    if ($urandom_range(0, 4) != 0) return BASE | {18'h0, 12'($urandom), 2'($urandom)};
    return 32'h0000_1000 + 32'($urandom_range(0, 255) * 4);
  endfunction

  typedef struct {
    logic        du_req, du_we;
    logic [3:0]  sel;
    logic [31:0] du_adr, du_dat;
    logic        if_req;
    logic [31:0] if_adr;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [11:0] exp_addr;
    logic [2:0]  exp_state;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1, 0, 4'h0, 32'h0080_0010, 32'h0, 0, 32'h0, 1, 4'h0, 12'h004, 3'd2};
    vecs[1] = '{1, 1, 4'h3, 32'h0080_0020, 32'h1234_5678, 0, 32'h0, 1, 4'h3, 12'h008, 3'd1};
    vecs[2] = '{0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h0080_3FFC, 1, 4'h0, 12'hFFF, 3'd3};
    vecs[3] = '{1, 0, 4'h0, 32'h0000_1000, 32'h0, 0, 32'h0, 0, 4'h0, 12'h000, 3'd0};
    vecs[4] = '{1, 0, 4'h0, 32'h0000_1000, 32'h0, 1, 32'h0080_0100, 1, 4'h0, 12'h040, 3'd3};
    vecs[5] = '{1, 1, 4'hF, 32'h0080_0004, 32'hA5A5_0F0F, 1, 32'h0080_0008, 1, 4'hF, 12'h001, 3'd1};
    vecs[6] = '{1, 0, 4'h0, 32'h0080_4000, 32'h0, 1, 32'h007F_FFFC, 0, 4'h0, 12'h000, 3'd0};
    vecs[7] = '{0, 1, 4'hF, 32'h0080_0040, 32'hFFFF_FFFF, 0, 32'h0080_0044, 0, 4'h0, 12'h000, 3'd0};

    bus.du_we_i = 1'b0; bus.du_sel_i = 4'h0; bus.du_adr_i = '0; bus.du_dat_i = '0;
    bus.if_adr_i = '0;

    // Reset with both requesters active: nothing may happen
    rst = 1'b0;
    du_drive(1'b1, 4'hF, 32'h0080_0000, 32'hFFFF_FFFF);
    if_drive(32'h0080_0004);
    advance();
    for (int i = 0; i < 2; i++) begin
      model_check();
      check("rst_state", 32'(bus.state_o), 32'd0);
      check("rst_ram_en", 32'(bus.ram_en_o), 32'd0);
      check("rst_acks", {30'd0, bus.du_ack_o, bus.if_ack_o}, 32'd0);
      check("rst_cnt", 32'(bus.if_stall_cnt_o), 32'd0);
      advance();
    end
    idle();
    rst = 1'b1;
    model_check(); advance();

    // Conflict: DU load beats IF, IF served the next cycle
    du_drive(1'b0, 4'h0, 32'h0080_0010, 32'h0);
    if_drive(32'h0080_0020);
    model_check();
    check("conf_addr0", 32'(bus.ram_addr_o), 32'd4);
    advance();
    model_check();
    check("conf_state_load", 32'(bus.state_o), 32'd2);
    check("conf_addr1", 32'(bus.ram_addr_o), 32'd8);
    check("conf_cnt", 32'(bus.if_stall_cnt_o), 32'd1);
    advance();
    bus.du_req_i = 1'b0;
    model_check();
    check("conf_state_fetch", 32'(bus.state_o), 32'd3);
    check("conf_if_ack", 32'(bus.if_ack_o), 32'd1);
    advance();
    idle();

    // Store DEADBEEF to word 4, partial store to word 8, then read both back
    du_drive(1'b1, 4'hF, 32'h0080_0010, 32'hDEAD_BEEF);
    model_check(); advance();
    idle();
    model_check(); advance();
    du_drive(1'b1, 4'b0011, 32'h0080_0020, 32'h1234_5678);
    model_check();
    check("st_we", 32'(bus.ram_we_o), 32'h3);
    check("st_addr", 32'(bus.ram_addr_o), 32'd8);
    advance();
    model_check();
    check("st_state", 32'(bus.state_o), 32'd1);
    check("st_ack", 32'(bus.du_ack_o), 32'd1);
    advance();
    du_drive(1'b0, 4'h0, 32'h0080_0010, 32'h0);
    model_check();
    check("ld_addr", 32'(bus.ram_addr_o), 32'd4);
    advance();
    model_check();
    check("ld_state", 32'(bus.state_o), 32'd2);
    check("ld_dat", bus.du_dat_o, 32'hDEAD_BEEF);
    advance();
    du_drive(1'b0, 4'h0, 32'h0080_0020, 32'h0);
    model_check(); advance();
    model_check();
    check("ld_partial", bus.du_dat_o, 32'h0000_5678);
    advance();
    idle();

    // Miss: never reaches the SRAM or the FSM
    du_drive(1'b0, 4'h0, 32'h0000_1000, 32'h0);
    model_check();
    check("miss_hit", 32'(bus.du_hit_o), 32'd0);
    check("miss_en", 32'(bus.ram_en_o), 32'd0);
    advance();
    model_check();
    check("miss_state", 32'(bus.state_o), 32'd0);
    check("miss_ack", 32'(bus.du_ack_o), 32'd0);
    advance();
    idle();

    // Reset right after a load grant: the ack must never appear
    du_drive(1'b0, 4'h0, 32'h0080_0010, 32'h0);
    model_check();
    rst = 1'b0;
    advance();
    for (int i = 0; i < 2; i++) begin
      model_check();
      check("midrst_state", 32'(bus.state_o), 32'd0);
      check("midrst_ack", 32'(bus.du_ack_o), 32'd0);
      advance();
    end
    idle();
    rst = 1'b1;
    model_check(); advance();

    // Vector table: one request pattern from idle, then its resulting state
    for (int v = 0; v < 8; v++) begin
      bus.du_req_i = vecs[v].du_req;
      bus.du_we_i  = vecs[v].du_we;
      bus.du_sel_i = vecs[v].sel;
      bus.du_adr_i = vecs[v].du_adr;
      bus.du_dat_i = vecs[v].du_dat;
      bus.if_req_i = vecs[v].if_req;
      bus.if_adr_i = vecs[v].if_adr;
      model_check();
      check($sformatf("vec%0d_en", v), 32'(bus.ram_en_o), 32'(vecs[v].exp_en));
      check($sformatf("vec%0d_we", v), 32'(bus.ram_we_o), 32'(vecs[v].exp_we));
      if (vecs[v].exp_en)
        check($sformatf("vec%0d_addr", v), 32'(bus.ram_addr_o), 32'(vecs[v].exp_addr));
      advance();
      idle();
      model_check();
      check($sformatf("vec%0d_state", v), 32'(bus.state_o), 32'(vecs[v].exp_state));
      advance();
      model_check(); advance();
    end

    // Randomized traffic: requests held until acked; misses dropped after one cycle
    for (int c = 0; c < 400; c++) begin
      model_check();
      advance();
      if (!bus.du_req_i || s_du_ack || !s_du_hit) begin
        if ($urandom_range(0, 1) == 1)
          du_drive(1'($urandom), 4'($urandom), rand_adr(), $urandom);
        else bus.du_req_i = 1'b0;
      end
      if (!bus.if_req_i || s_if_ack || !s_if_hit) begin
        if ($urandom_range(0, 2) != 0) if_drive(rand_adr());
        else bus.if_req_i = 1'b0;
      end
    end
    idle();
    model_check(); advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
